// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: one registered 32-bit ALU shared by two valid/ready requesters.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.

module alu_share_core (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  ctrl,
  output logic [31:0] result,
  output logic [3:0]  flags
);
  logic [31:0] bb, sum;
  logic        cout, ovf;

  always_comb begin
    bb = ctrl[0] ? ~b : b;
    {cout, sum} = {1'b0, a} + {1'b0, bb} + {32'd0, ctrl[0]};
    ovf = ~ctrl[1] & ~(ctrl[0] ^ a[31] ^ b[31]) & (a[31] ^ sum[31]);
    case (ctrl)
      3'b000, 3'b001: result = sum;
      3'b010:         result = a & b;
      3'b011:         result = a | b;
      3'b101:         result = {31'd0, sum[31]};
      default:        result = '0;
    endcase
    // {Carry, OverFlow, Zero, Negative}
    flags = {~ctrl[1] & cout, ovf, result == 32'd0, result[31]};
  end
endmodule

module alu_share_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s0_valid,
  output logic             s0_ready,
  input  logic [31:0]      s0_a,
  input  logic [31:0]      s0_b,
  input  logic [2:0]       s0_ctrl,
  input  logic             s1_valid,
  output logic             s1_ready,
  input  logic [31:0]      s1_a,
  input  logic [31:0]      s1_b,
  input  logic [2:0]       s1_ctrl,
  output logic             r0_valid,
  input  logic             r0_ready,
  output logic [31:0]      r0_result,
  output logic [3:0]       r0_flags,
  output logic             r1_valid,
  input  logic             r1_ready,
  output logic [31:0]      r1_result,
  output logic [3:0]       r1_flags,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt
);
`ifdef ALU_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
  } alu_req_t;

  state_t      state, state_nxt;
  alu_req_t    req_q, req_sel;
  logic        owner, last_grant, grant, req_hs, rsp_hs;
  logic [31:0] result_q, alu_result;
  logic [3:0]  flags_q, alu_flags;

  // grant=1 selects port 1; on contention round-robin flips away from last_grant
  always_comb begin
    grant = 1'b0;
    if (s0_valid && s1_valid) grant = RR_EN & ~last_grant;
    else if (s1_valid)        grant = 1'b1;
    req_sel = grant ? '{a: s1_a, b: s1_b, ctrl: s1_ctrl}
                    : '{a: s0_a, b: s0_b, ctrl: s0_ctrl};
  end

  always_comb begin
    state_nxt = state;
    s0_ready  = 1'b0;
    s1_ready  = 1'b0;
    r0_valid  = 1'b0;
    r1_valid  = 1'b0;
    req_hs    = 1'b0;
    rsp_hs    = 1'b0;
    case (state)
      IDLE: begin
        s0_ready = s0_valid & ~grant;
        s1_ready = s1_valid & grant;
        req_hs   = s0_ready | s1_ready;
        if (req_hs) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        r0_valid = ~owner;
        r1_valid = owner;
        rsp_hs   = owner ? r1_ready : r0_ready;
        if (rsp_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  alu_share_core u_alu (
    .a      (req_q.a),
    .b      (req_q.b),
    .ctrl   (req_q.ctrl),
    .result (alu_result),
    .flags  (alu_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_q      <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      result_q   <= '0;
      flags_q    <= '0;
      op_cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (req_hs) begin
        req_q      <= req_sel;
        owner      <= grant;
        last_grant <= grant;
      end
      if (state == EXEC) begin
        result_q <= alu_result;
        flags_q  <= alu_flags;
      end
      if (rsp_hs && (op_cnt != '1)) op_cnt <= op_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign busy      = (state != IDLE);
  assign r0_result = result_q;
  assign r1_result = result_q;
  assign r0_flags  = flags_q;
  assign r1_flags  = flags_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed table, multi-cycle sequences and
// randomized traffic against a behavioural ALU/arbitration model.

module tb_alu_share_arbiter;
`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        s0_valid, s1_valid, s0_ready, s1_ready;
  logic [31:0] s0_a, s0_b, s1_a, s1_b;
  logic [2:0]  s0_ctrl, s1_ctrl;
  logic        r0_valid, r1_valid, r0_ready, r1_ready, busy;
  logic [31:0] r0_result, r1_result;
  logic [3:0]  r0_flags, r1_flags;
  logic [15:0] op_cnt;
  // second instance with a 2-bit counter to exercise saturation
  logic        n_s0_ready, n_s1_ready, n_r0_valid, n_r1_valid, n_busy;
  logic [31:0] n_r0_result, n_r1_result;
  logic [3:0]  n_r0_flags, n_r1_flags;
  logic [1:0]  op_cnt2;

  always #5 clk = ~clk;

  alu_share_arbiter #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_a(s0_a), .s0_b(s0_b), .s0_ctrl(s0_ctrl),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_a(s1_a), .s1_b(s1_b), .s1_ctrl(s1_ctrl),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_result(r0_result), .r0_flags(r0_flags),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_result(r1_result), .r1_flags(r1_flags),
    .busy(busy), .op_cnt(op_cnt)
  );

  alu_share_arbiter #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(n_s0_ready), .s0_a(s0_a), .s0_b(s0_b), .s0_ctrl(s0_ctrl),
    .s1_valid(s1_valid), .s1_ready(n_s1_ready), .s1_a(s1_a), .s1_b(s1_b), .s1_ctrl(s1_ctrl),
    .r0_valid(n_r0_valid), .r0_ready(r0_ready), .r0_result(n_r0_result), .r0_flags(n_r0_flags),
    .r1_valid(n_r1_valid), .r1_ready(r1_ready), .r1_result(n_r1_result), .r1_flags(n_r1_flags),
    .busy(n_busy), .op_cnt(op_cnt2)
  );

  int checks = 0, errors = 0;
  int exp_cnt, exp_cnt2;
  bit exp_last;

  typedef struct {
    bit          port;
    logic [31:0] a, b;
    logic [2:0]  ctrl;
    logic [31:0] exp_res;
    logic [3:0]  exp_fl;
    logic [3:0]  fmask;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic rv(input bit p);
    return p ? r1_valid : r0_valid;
  endfunction

  // reference ALU from signed/unsigned integer arithmetic: {result, C, V, Z, N}
  function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] c);
    longint sa, sb, ua, ub, s;
    logic [31:0] r, d;
    logic cf, vf;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
    cf = 1'b0; vf = 1'b0; r = '0; d = a - b;
    case (c)
      3'd0: begin
        r = a + b; cf = (ua + ub) > 64'sd4294967295; s = sa + sb;
        vf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd1, 3'd5: begin
        r = (c == 3'd1) ? d : {31'd0, d[31]}; cf = (ua >= ub); s = sa - sb;
        vf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      default: r = '0;
    endcase
    return {r, cf, vf, r == 32'd0, r[31]};
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_s0_ready"}, s0_ready, 0);  chk({tag, "_s1_ready"}, s1_ready, 0);
    chk({tag, "_r0_valid"}, r0_valid, 0);  chk({tag, "_r1_valid"}, r1_valid, 0);
    chk({tag, "_busy"}, busy, 0);          chk({tag, "_op_cnt"}, op_cnt, 0);
    chk({tag, "_result"}, r0_result, 0);   chk({tag, "_flags"}, r0_flags, 0);
    chk({tag, "_op_cnt2"}, op_cnt2, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; s0_valid = 0; s1_valid = 0; r0_ready = 0; r1_ready = 0;
    @(posedge clk); #1;
    rst = 0; exp_cnt = 0; exp_cnt2 = 0; exp_last = 1'b1;
  endtask

  // one transaction: present requests, check arbitration, latency, stall stability, counters
  task automatic do_op(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [2:0] c0, input logic [31:0] a1, input logic [31:0] b1,
                       input logic [2:0] c1, input int stall, input bit press,
                       output bit ew, output logic [31:0] res, output logic [3:0] fl);
    bit seen;
    int wait_cyc;
    ew = (v == 2'b11) ? (RR ? ~exp_last : 1'b0) : (v == 2'b10);
    res = '0; fl = '0; seen = 0; wait_cyc = 0;
    @(posedge clk); #1;
    s0_valid = v[0]; s0_a = a0; s0_b = b0; s0_ctrl = c0;
    s1_valid = v[1]; s1_a = a1; s1_b = b1; s1_ctrl = c1;
    r0_ready = (stall == 0); r1_ready = (stall == 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (s0_ready | s1_ready) begin seen = 1; wait_cyc = k; break; end
    end
    if (!seen) begin
      chk("accept_timeout", 0, 1);
      @(posedge clk); #1; s0_valid = 0; s1_valid = 0;
      return;
    end
    chk("accept_same_cycle", wait_cyc, 0);
    chk("grant", s1_ready, ew);
    chk("one_ready", s0_ready & s1_ready, 0);
    exp_last = ew;
    @(posedge clk); #1; s0_valid = 0; s1_valid = 0;
    @(negedge clk);
    chk("exec_busy", busy, 1);
    chk("exec_rvalid", r0_valid | r1_valid, 0);
    @(negedge clk);
    chk("resp_valid", rv(ew), 1);
    chk("other_rvalid", rv(~ew), 0);
    res = ew ? r1_result : r0_result;
    fl  = ew ? r1_flags : r0_flags;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      if (press) begin s0_valid = 1; s1_valid = 1; end
      if (s == stall - 1) begin r0_ready = 1; r1_ready = 1; end
      @(negedge clk);
      chk("stall_valid", rv(ew), 1);
      chk("stall_result", ew ? r1_result : r0_result, res);
      chk("stall_flags", ew ? r1_flags : r0_flags, fl);
      chk("stall_busy", busy, 1);
      chk("stall_cnt", op_cnt, exp_cnt);
      chk("stall_s_ready", s0_ready | s1_ready, 0);
    end
    @(posedge clk); #1;
    s0_valid = 0; s1_valid = 0; r0_ready = 0; r1_ready = 0;
    exp_cnt  = (exp_cnt == 65535) ? exp_cnt : exp_cnt + 1;
    exp_cnt2 = (exp_cnt2 == 3) ? 3 : exp_cnt2 + 1;
    @(negedge clk);
    chk("op_cnt", op_cnt, exp_cnt);
    chk("op_cnt_w2", op_cnt2, exp_cnt2);
    chk("idle_busy", busy, 0);
  endtask

  bit          win, ew;
  logic [31:0] res, ra0, rb0, ra1, rb1;
  logic [3:0]  fl, m;
  logic [2:0]  rc0, rc1;
  logic [1:0]  rvv;
  logic [35:0] expv;
  int          ng;

  initial begin
    tbl[0] = '{0, 32'd5,          32'd3,          3'b001, 32'd2,          4'b1000, 4'hF};
    tbl[1] = '{1, 32'hFFFFFFFF,   32'd1,          3'b000, 32'd0,          4'b1010, 4'hF};
    tbl[2] = '{0, 32'd2,          32'd5,          3'b101, 32'd1,          4'b0000, 4'hF};
    tbl[3] = '{1, 32'hF0F0F0F0,   32'hFF00FF00,   3'b010, 32'hF000F000,   4'b0001, 4'h3};
    tbl[4] = '{0, 32'h7FFFFFFF,   32'd1,          3'b000, 32'h80000000,   4'b0101, 4'hF};
    tbl[5] = '{1, 32'd0,          32'd0,          3'b001, 32'd0,          4'b1010, 4'hF};
    tbl[6] = '{0, 32'h12345678,   32'd1,          3'b011, 32'h12345679,   4'b0000, 4'h3};
    tbl[7] = '{1, 32'h0000DEAD,   32'h0000BEEF,   3'b110, 32'd0,          4'b0010, 4'h3};
    tbl[8] = '{0, 32'h80000000,   32'd1,          3'b001, 32'h7FFFFFFF,   4'b1100, 4'hF};

    rst = 1; s0_valid = 0; s1_valid = 0; r0_ready = 0; r1_ready = 0;
    s0_a = 0; s0_b = 0; s0_ctrl = 0; s1_a = 0; s1_b = 0; s1_ctrl = 0;
    exp_cnt = 0; exp_cnt2 = 0; exp_last = 1'b1;
    @(negedge clk);
    check_reset("rst");
    @(posedge clk); #1; rst = 0;

    // directed vectors, op_cnt2 saturates at 3 along the way
    foreach (tbl[i]) begin
      do_op(tbl[i].port ? 2'b10 : 2'b01, tbl[i].a, tbl[i].b, tbl[i].ctrl,
            tbl[i].a, tbl[i].b, tbl[i].ctrl, 0, 1'b0, win, res, fl);
      chk("tbl_result", res, tbl[i].exp_res);
      chk("tbl_flags", fl & tbl[i].fmask, tbl[i].exp_fl & tbl[i].fmask);
    end

    // both requesters valid continuously for four operations
    do_reset();
    @(posedge clk); #1;
    s0_valid = 1; s0_a = 10; s0_b = 3; s0_ctrl = 3'b000;
    s1_valid = 1; s1_a = 10; s1_b = 3; s1_ctrl = 3'b001;
    r0_ready = 1; r1_ready = 1; ng = 0;
    for (int k = 0; k < 40 && ng < 4; k++) begin
      @(negedge clk);
      if (r0_valid) chk("both_r0_result", r0_result, 13);
      if (r1_valid) chk("both_r1_result", r1_result, 7);
      if (s0_ready | s1_ready) begin
        ew = RR ? ~exp_last : 1'b0;
        chk("both_grant", s1_ready, ew);
        chk("both_one_ready", s0_ready & s1_ready, 0);
        exp_last = ew; ng++;
        if (ng == 4) begin @(posedge clk); #1; s0_valid = 0; s1_valid = 0; end
      end
    end
    chk("both_ops", ng, 4);
    repeat (3) @(negedge clk);
    exp_cnt += 4; exp_cnt2 = 3;
    chk("both_op_cnt", op_cnt, exp_cnt);
    chk("both_op_cnt2", op_cnt2, exp_cnt2);
    @(posedge clk); #1; r0_ready = 0; r1_ready = 0;

    // response stalled for 5 cycles while both requesters press new requests
    do_op(2'b01, 32'd100, 32'd58, 3'b001, 32'd1, 32'd1, 3'b000, 5, 1'b1, win, res, fl);
    chk("stall_final_result", res, 42);
    chk("stall_final_flags", fl, 4'b1000);

    // reset while the operation is in EXEC
    do_reset();
    @(posedge clk); #1;
    s0_valid = 1; s0_a = 7; s0_b = 9; s0_ctrl = 3'b000; r0_ready = 1;
    @(negedge clk);
    chk("midrst_accept", s0_ready, 1);
    @(posedge clk); #1; s0_valid = 0; rst = 1;
    @(negedge clk);
    check_reset("midrst");
    @(posedge clk); #1; rst = 0; exp_cnt = 0; exp_cnt2 = 0; exp_last = 1'b1;
    @(negedge clk);
    chk("midrst_no_resp", r0_valid | r1_valid | busy, 0);
    do_op(2'b01, 32'd2, 32'd5, 3'b101, 32'd0, 32'd0, 3'b000, 0, 1'b0, win, res, fl);
    chk("midrst_slt_result", res, 1);
    chk("midrst_slt_flags", fl, 4'b0000);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      rvv = 2'($urandom_range(1, 3));
      ra0 = $urandom; rb0 = $urandom; rc0 = 3'($urandom_range(0, 7));
      ra1 = $urandom; rb1 = $urandom; rc1 = 3'($urandom_range(0, 7));
      if (i % 5 == 0) begin ra0 = 32'hFFFFFFFF; rb0 = 32'h80000000; ra1 = 32'h7FFFFFFF; rb1 = 32'hFFFFFFFF; end
      do_op(rvv, ra0, rb0, rc0, ra1, rb1, rc1, $urandom_range(0, 3), 1'b0, win, res, fl);
      expv = win ? alu_ref(ra1, rb1, rc1) : alu_ref(ra0, rb0, rc0);
      m = ((win ? rc1 : rc0) inside {3'd0, 3'd1, 3'd5}) ? 4'hF : 4'h3;
      chk("rnd_result", res, expv[35:4]);
      chk("rnd_flags", fl & m, expv[3:0] & m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
